mmio_uart: RTL

- Memory-mapped UART peripheral on the CPU data-memory bus. Sits downstream of the EX_DM stage, in parallel with the data memory.
- Decodes three word addresses. Serialises bytes written by software onto TX and deserialises RX into a FIFO that software pops.
- The CPU top muxes `rd_data` into the DM_WB path whenever `hit` was asserted for a read.

---
 rtl/mmio_uart.sv | 297 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart.sv
// ============================================================================
// Module      : mmio_uart
// Description : Memory-mapped UART on the data-memory bus. TRX/STATUS/DIV
//               registers, TX and RX FIFOs, 8N1 serialiser and deserialiser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_uart #(
    parameter logic [15:0] BASE       = 16'hC004,
    parameter logic [15:0] DIV_RST    = 16'd5207,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wrt_data,
    output logic        hit,
    output logic [15:0] rd_data,
    output logic        TX,
    input  logic        RX
);

    localparam int                 c_addr_w = $clog2(FIFO_DEPTH);
    localparam int                 c_cnt_w  = c_addr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    // Bus decode and register file
    logic [16:0]         w_off;
    logic                w_sel_trx;
    logic                w_sel_stat;
    logic                w_sel_div;
    logic [15:0]         div_q;
    logic [15:0]         rd_data_q;
    logic [15:0]         rd_data_d;
    logic                ovr_q;
    logic [2:0]          w_tx_free;
    logic [15:0]         w_half;

    // TX FIFO and serialiser
    logic [7:0]          tx_mem_q [FIFO_DEPTH];
    logic [c_addr_w-1:0] tx_wp_q;
    logic [c_addr_w-1:0] tx_rp_q;
    logic [c_cnt_w-1:0]  tx_cnt_q;
    logic                w_tx_push;
    logic                w_tx_pop;
    state_e              tx_st_q;
    logic [15:0]         tx_ctr_q;
    logic [2:0]          tx_bit_q;
    logic [7:0]          tx_sh_q;
    logic                tx_q;

    // RX synchroniser, deserialiser and FIFO
    logic                rx_s1_q;
    logic                rx_s2_q;
    logic                rx_prev_q;
    state_e              rx_st_q;
    logic [15:0]         rx_ctr_q;
    logic [2:0]          rx_bit_q;
    logic [7:0]          rx_sh_q;
    logic [7:0]          rx_mem_q [FIFO_DEPTH];
    logic [c_addr_w-1:0] rx_wp_q;
    logic [c_addr_w-1:0] rx_rp_q;
    logic [c_cnt_w-1:0]  rx_cnt_q;
    logic                w_rx_done;
    logic                w_rx_push;
    logic                w_rx_pop;
    logic                w_ovr_set;
    logic                w_ovr_clr;

    // Addresses below BASE wrap to large offsets, so one compare covers the window
    assign w_off      = {1'b0, addr} - {1'b0, BASE};
    assign hit        = (w_off < 17'd3);
    assign w_sel_trx  = hit && (w_off[1:0] == 2'd0);
    assign w_sel_stat = hit && (w_off[1:0] == 2'd1);
    assign w_sel_div  = hit && (w_off[1:0] == 2'd2);

    assign w_tx_pop  = (tx_cnt_q != '0) &&
                       ((tx_st_q == S_IDLE) || ((tx_st_q == S_STOP) && (tx_ctr_q == 16'd0)));
    assign w_tx_push = we && w_sel_trx && ((tx_cnt_q != c_depth) || w_tx_pop);

    assign w_rx_pop  = re && w_sel_trx && (rx_cnt_q != '0);
    assign w_rx_done = (rx_st_q == S_STOP) && (rx_ctr_q == 16'd0);
    assign w_rx_push = w_rx_done && rx_s2_q && ((rx_cnt_q != c_depth) || w_rx_pop);
    assign w_ovr_set = w_rx_done && rx_s2_q && (rx_cnt_q == c_depth) && !w_rx_pop;
    assign w_ovr_clr = re && w_sel_stat;

    assign w_half    = {1'b0, div_q[15:1]} + {15'd0, div_q[0]};
    assign w_tx_free = 3'(c_depth - tx_cnt_q);

    assign rd_data = rd_data_q;
    assign TX      = tx_q;

    always_comb begin
        rd_data_d = 16'h0000;
        if (re && hit) begin
            if (w_sel_trx) begin
                if (rx_cnt_q != '0) begin
                    rd_data_d = {8'h00, rx_mem_q[rx_rp_q]};
                end
            end else if (w_sel_stat) begin
                rd_data_d = {7'b0, ovr_q, 1'b0, w_tx_free, 1'b0, 3'(rx_cnt_q)};
            end else begin
                rd_data_d = div_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= 16'h0000;
            div_q     <= DIV_RST;
            ovr_q     <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            if (we && w_sel_div) begin
                div_q <= wrt_data;
            end
            // A new overrun on the clearing edge must not be lost
            ovr_q <= w_ovr_set | (ovr_q & ~w_ovr_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            tx_mem_q[tx_wp_q] <= wrt_data[7:0];
        end
        if (w_rx_push) begin
            rx_mem_q[rx_wp_q] <= rx_sh_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (w_tx_push) tx_wp_q <= tx_wp_q + c_addr_w'(1);
            if (w_tx_pop)  tx_rp_q <= tx_rp_q + c_addr_w'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   tx_cnt_q <= tx_cnt_q + c_cnt_w'(1);
                2'b01:   tx_cnt_q <= tx_cnt_q - c_cnt_w'(1);
                default: tx_cnt_q <= tx_cnt_q;
            endcase
            if (w_rx_push) rx_wp_q <= rx_wp_q + c_addr_w'(1);
            if (w_rx_pop)  rx_rp_q <= rx_rp_q + c_addr_w'(1);
            case ({w_rx_push, w_rx_pop})
                2'b10:   rx_cnt_q <= rx_cnt_q + c_cnt_w'(1);
                2'b01:   rx_cnt_q <= rx_cnt_q - c_cnt_w'(1);
                default: rx_cnt_q <= rx_cnt_q;
            endcase
        end
    end

    // Every bit boundary reloads the counter from div_q, so DIV writes land there
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st_q  <= S_IDLE;
            tx_ctr_q <= 16'd0;
            tx_bit_q <= 3'd0;
            tx_sh_q  <= 8'h00;
            tx_q     <= 1'b1;
        end else begin
            case (tx_st_q)
                S_IDLE: begin
                    if (w_tx_pop) begin
                        tx_sh_q  <= tx_mem_q[tx_rp_q];
                        tx_q     <= 1'b0;
                        tx_ctr_q <= div_q;
                        tx_st_q  <= S_START;
                    end
                end
                S_START: begin
                    if (tx_ctr_q == 16'd0) begin
                        tx_q     <= tx_sh_q[0];
                        tx_ctr_q <= div_q;
                        tx_bit_q <= 3'd0;
                        tx_st_q  <= S_DATA;
                    end else begin
                        tx_ctr_q <= tx_ctr_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (tx_ctr_q == 16'd0) begin
                        tx_ctr_q <= div_q;
                        if (tx_bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            tx_st_q <= S_STOP;
                        end else begin
                            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                            tx_q     <= tx_sh_q[1];
                            tx_bit_q <= tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_ctr_q <= tx_ctr_q - 16'd1;
                    end
                end
                S_STOP: begin
                    if (tx_ctr_q == 16'd0) begin
                        if (w_tx_pop) begin
                            tx_sh_q  <= tx_mem_q[tx_rp_q];
                            tx_q     <= 1'b0;
                            tx_ctr_q <= div_q;
                            tx_st_q  <= S_START;
                        end else begin
                            tx_st_q <= S_IDLE;
                        end
                    end else begin
                        tx_ctr_q <= tx_ctr_q - 16'd1;
                    end
                end
                default: tx_st_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= RX;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // START waits half a bit so all later samples fall near mid-bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_st_q  <= S_IDLE;
            rx_ctr_q <= 16'd0;
            rx_bit_q <= 3'd0;
            rx_sh_q  <= 8'h00;
        end else begin
            case (rx_st_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_ctr_q <= w_half;
                        rx_st_q  <= S_START;
                    end
                end
                S_START: begin
                    if (rx_ctr_q <= 16'd1) begin
                        if (!rx_s2_q) begin
                            rx_ctr_q <= div_q;
                            rx_bit_q <= 3'd0;
                            rx_st_q  <= S_DATA;
                        end else begin
                            rx_st_q <= S_IDLE;
                        end
                    end else begin
                        rx_ctr_q <= rx_ctr_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_ctr_q == 16'd0) begin
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                        rx_ctr_q <= div_q;
                        if (rx_bit_q == 3'd7) begin
                            rx_st_q <= S_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_ctr_q <= rx_ctr_q - 16'd1;
                    end
                end
                S_STOP: begin
                    if (rx_ctr_q == 16'd0) begin
                        rx_st_q <= S_IDLE;
                    end else begin
                        rx_ctr_q <= rx_ctr_q - 16'd1;
                    end
                end
                default: rx_st_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
